// File: rtl/caliptra_fpga_clk_step_ctrl.sv
// Run/step sequencer for the FPGA wrapper's gated Caliptra clock.
// Issues a burst of enabled cycles and halts on budget, wire change, cycle breakpoint or abort.
module caliptra_fpga_clk_step_ctrl #(
  parameter int CNT_W  = 32,
  parameter int CYC_W  = 64,
  parameter int WIRE_W = 64
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic              go,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cycle_count,
  input  logic              bkpt_wires_en,
  input  logic              bkpt_cycle_en,
  input  logic [CYC_W-1:0]  bkpt_cycle,
  input  logic [WIRE_W-1:0] generic_output_wires,
  output logic              clk_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining,
  output logic [CYC_W-1:0]  gated_cycles,
  output logic [1:0]        halt_cause
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUDGET = 2'd1;
  localparam logic [1:0] CAUSE_WIRES  = 2'd2;
  localparam logic [1:0] CAUSE_CYCLE  = 2'd3;

  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic              go_q;
  logic [WIRE_W-1:0] wires_prev;
  logic [CYC_W-1:0]  cyc_next;
  logic              run_now;
  logic              hit_abort;
  logic              hit_wire;
  logic              hit_cyc;
  logic              hit_bud;

  assign run_now   = (state == ST_RUN);
  assign cyc_next  = gated_cycles + CYC_ONE;
  assign hit_abort = abort;
  assign hit_wire  = bkpt_wires_en && (generic_output_wires != wires_prev);
  assign hit_cyc   = bkpt_cycle_en && (cyc_next == bkpt_cycle);
  assign hit_bud   = (remaining == CNT_ONE);

  // Reset kills the enable combinationally so a mid-burst reset stops the gated clock at once.
  assign clk_en = rstn && run_now && !hit_abort && !hit_wire;
  assign busy   = run_now;

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      gated_cycles <= '0;
      halt_cause   <= CAUSE_NONE;
      done         <= 1'b0;
      go_q         <= 1'b0;
      wires_prev   <= '0;
    end else begin
      go_q <= go;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go && !go_q) begin
            if (cycle_count == '0) begin
              state      <= ST_HALT;
              halt_cause <= CAUSE_BUDGET;
              done       <= 1'b1;
            end else begin
              state      <= ST_RUN;
              remaining  <= cycle_count;
              wires_prev <= generic_output_wires;
              halt_cause <= CAUSE_NONE;
            end
          end
        end
        ST_RUN: begin
          if (hit_abort) begin
            state      <= ST_HALT;
            halt_cause <= CAUSE_NONE;
            done       <= 1'b1;
          end else if (hit_wire) begin
            state      <= ST_HALT;
            halt_cause <= CAUSE_WIRES;
            done       <= 1'b1;
          end else begin
            // Enabled cycle: a cycle or budget hit makes this the final enabled cycle.
            gated_cycles <= cyc_next;
            remaining    <= remaining - CNT_ONE;
            wires_prev   <= generic_output_wires;
            if (hit_cyc) begin
              state      <= ST_HALT;
              halt_cause <= CAUSE_CYCLE;
              done       <= 1'b1;
            end else if (hit_bud) begin
              state      <= ST_HALT;
              halt_cause <= CAUSE_BUDGET;
              done       <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (!go) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_clk_step_ctrl.sv
// Bench for caliptra_fpga_clk_step_ctrl: directed scenarios plus random traffic,
// every cycle checked against a burst-level reference model.
module tb_caliptra_fpga_clk_step_ctrl;

  logic        aclk;
  logic        rstn;
  logic        go;
  logic        abort;
  logic [31:0] cycle_count;
  logic        bkpt_wires_en;
  logic        bkpt_cycle_en;
  logic [63:0] bkpt_cycle;
  logic [63:0] generic_output_wires;
  logic        clk_en;
  logic        busy;
  logic        done;
  logic [31:0] remaining;
  logic [63:0] gated_cycles;
  logic [1:0]  halt_cause;

  int checks;
  int fails;
  int en_seen;

  // Reference model: 0 idle, 1 running a burst, 2 halted waiting for go to drop
  int          m_phase;
  logic [31:0] m_left;
  logic [63:0] m_total;
  logic [1:0]  m_cause;
  bit          m_done;
  bit          m_goprev;
  logic [63:0] m_snap;

  caliptra_fpga_clk_step_ctrl #(.CNT_W(32), .CYC_W(64), .WIRE_W(64)) dut (
    .aclk                 (aclk),
    .rstn                 (rstn),
    .go                   (go),
    .abort                (abort),
    .cycle_count          (cycle_count),
    .bkpt_wires_en        (bkpt_wires_en),
    .bkpt_cycle_en        (bkpt_cycle_en),
    .bkpt_cycle           (bkpt_cycle),
    .generic_output_wires (generic_output_wires),
    .clk_en               (clk_en),
    .busy                 (busy),
    .done                 (done),
    .remaining            (remaining),
    .gated_cycles         (gated_cycles),
    .halt_cause           (halt_cause)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  function automatic bit modelEnable();
    if (!rstn || m_phase != 1) return 1'b0;
    if (abort) return 1'b0;
    if (bkpt_wires_en && generic_output_wires != m_snap) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelClock(input bit en);
    if (!rstn) begin
      m_phase = 0; m_left = 0; m_total = 0; m_cause = 0;
      m_done = 0; m_goprev = 0; m_snap = 0;
      return;
    end
    m_done = 0;
    if (m_phase == 0) begin
      if (go && !m_goprev) begin
        if (cycle_count == 0) begin
          m_phase = 2; m_cause = 1; m_done = 1;
        end else begin
          m_phase = 1; m_left = cycle_count; m_snap = generic_output_wires; m_cause = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (en) begin
        m_total = m_total + 1;
        m_left  = m_left - 1;
        m_snap  = generic_output_wires;
        if (bkpt_cycle_en && m_total == bkpt_cycle) begin
          m_phase = 2; m_cause = 3; m_done = 1;
        end else if (m_left == 0) begin
          m_phase = 2; m_cause = 1; m_done = 1;
        end
      end else begin
        m_phase = 2; m_done = 1;
        m_cause = abort ? 2'd0 : 2'd2;
      end
    end else if (!go) begin
      m_phase = 0;
    end
    m_goprev = go;
  endtask

  // Inputs are set by the caller just after a rising edge; this runs one full clock.
  task automatic applyStimulus();
    bit en;
    #3;
    en = modelEnable();
    checkOutput("clk_en", {63'd0, clk_en}, {63'd0, en});
    checkOutput("busy_pre", {63'd0, busy}, {63'd0, m_phase == 1});
    if (clk_en) en_seen++;
    @(posedge aclk);
    modelClock(en);
    #1;
    checkOutput("done", {63'd0, done}, {63'd0, m_done});
    checkOutput("busy", {63'd0, busy}, {63'd0, m_phase == 1});
    checkOutput("remaining", {32'd0, remaining}, {32'd0, m_left});
    checkOutput("gated_cycles", gated_cycles, m_total);
    checkOutput("halt_cause", {62'd0, halt_cause}, {62'd0, m_cause});
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  logic [63:0] base_total;

  initial begin
    checks = 0; fails = 0; en_seen = 0;
    rstn = 1'b0; go = 1'b0; abort = 1'b0; cycle_count = '0;
    bkpt_wires_en = 1'b0; bkpt_cycle_en = 1'b0; bkpt_cycle = '0;
    generic_output_wires = 64'h1234_5678_9abc_def0;
    m_phase = 0; m_left = 0; m_total = 0; m_cause = 0;
    m_done = 0; m_goprev = 0; m_snap = 0;
    @(posedge aclk); #1;
    runCycles(2);
    checkOutput("reset_total", gated_cycles, 64'd0);
    checkOutput("reset_cause", {62'd0, halt_cause}, 64'd0);
    rstn = 1'b1;
    runCycles(1);

    // Plain budget burst of 5
    en_seen = 0;
    go = 1'b1; cycle_count = 32'd5;
    runCycles(8);
    go = 1'b0;
    runCycles(1);
    checkOutput("t1_enabled", 64'(en_seen), 64'd5);
    checkOutput("t1_total", gated_cycles, 64'd5);
    checkOutput("t1_cause", {62'd0, halt_cause}, 64'd1);
    checkOutput("t1_remaining", {32'd0, remaining}, 64'd0);

    // Zero budget halts straight away
    en_seen = 0;
    go = 1'b1; cycle_count = 32'd0;
    runCycles(3);
    go = 1'b0;
    runCycles(2);
    checkOutput("t2_enabled", 64'(en_seen), 64'd0);
    checkOutput("t2_total", gated_cycles, 64'd5);

    // Wire change after the third enabled cycle
    bkpt_wires_en = 1'b1; cycle_count = 32'd100; go = 1'b1;
    runCycles(4);
    generic_output_wires = generic_output_wires ^ 64'h10;
    runCycles(2);
    checkOutput("t3_cause", {62'd0, halt_cause}, 64'd2);
    checkOutput("t3_remaining", {32'd0, remaining}, 64'd97);
    go = 1'b0; bkpt_wires_en = 1'b0;
    runCycles(1);

    // Cycle breakpoint three cycles ahead
    base_total = m_total;
    bkpt_cycle_en = 1'b1; bkpt_cycle = base_total + 64'd3; cycle_count = 32'd50; go = 1'b1;
    runCycles(6);
    checkOutput("t4_cause", {62'd0, halt_cause}, 64'd3);
    checkOutput("t4_total", gated_cycles, base_total + 64'd3);
    checkOutput("t4_remaining", {32'd0, remaining}, 64'd47);
    go = 1'b0; bkpt_cycle_en = 1'b0;
    runCycles(1);

    // Abort together with a wire change
    cycle_count = 32'd20; go = 1'b1; bkpt_wires_en = 1'b1;
    runCycles(3);
    abort = 1'b1; generic_output_wires = ~generic_output_wires;
    runCycles(1);
    abort = 1'b0;
    checkOutput("t5_cause", {62'd0, halt_cause}, 64'd0);
    go = 1'b0; bkpt_wires_en = 1'b0;
    runCycles(1);

    // Reset mid-burst
    go = 1'b1; cycle_count = 32'd30;
    runCycles(3);
    rstn = 1'b0;
    runCycles(1);
    checkOutput("t5_rst_total", gated_cycles, 64'd0);
    rstn = 1'b1; go = 1'b0;
    runCycles(1);

    // go held high after halt, then re-armed
    en_seen = 0;
    go = 1'b1; cycle_count = 32'd2;
    runCycles(10);
    checkOutput("t6_held", 64'(en_seen), 64'd2);
    go = 1'b0;
    runCycles(1);
    go = 1'b1;
    runCycles(4);
    checkOutput("t6_rerun", 64'(en_seen), 64'd4);
    go = 1'b0;
    runCycles(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) go = ~go;
      abort = ($urandom_range(0, 29) == 0);
      rstn  = ($urandom_range(0, 199) != 0);
      cycle_count = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) generic_output_wires = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) begin
        bkpt_wires_en = 1'($urandom_range(0, 1));
        bkpt_cycle_en = 1'($urandom_range(0, 1));
        bkpt_cycle    = m_total + 64'($urandom_range(1, 6));
      end
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
